// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Round-robin arbiter for the single write port of the register file.
//   Port 0 is the load unit and port 1 is the ALU. Each has a valid/ready
//   handshake. A write accepted in cycle N appears on rf_we/rf_waddr/rf_wdata
//   in cycle N+1. These outputs come only from registers, so there is no
//   combinational path from any input to them.
//
//   Optional build macro: RF_CLEAR_EN
//     defined   : after reset, a sweep writes zero to x1..x(NREG-1) before
//                 any request is accepted.
//     undefined : no sweep. Requests are accepted once init_done registers
//                 high, which happens on the first edge after reset release.
//
//   state   | meaning (RF_CLEAR_EN builds only)
//   --------+------------------------------------------------------------
//   ST_INIT | clear sweep: one zero write per cycle, requesters held off
//   ST_RUN  | normal round-robin arbitration of load / ALU writebacks
//
// Ports
//   clk, reset            rising-edge clock, async active-low reset
//   ld_valid/ld_rd/ld_data/ld_ready       load writeback handshake
//   alu_valid/alu_rd/alu_data/alu_ready   ALU writeback handshake
//   rf_we/rf_waddr/rf_wdata               registered register-file write port
//   init_done                             high while requests can be accepted
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  // ptr_q = 0 favours the load port, 1 favours the ALU port
  logic              ptr_q, ptr_d;
  logic              ld_gnt, alu_gnt;
  logic              we_d, done_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;

`ifdef RF_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif

  // x0 is hardwired to zero, and indices beyond NREG do not exist, so
  // writes to either are accepted but dropped.
  function automatic logic writable(input logic [ADDR_W-1:0] rd);
    return (rd != '0) && (32'(rd) < NREG);
  endfunction

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = rf_waddr;
    wdata_d = rf_wdata;
    // init_done is low for the whole sweep, so it also gates the grants.
    ld_gnt  = init_done & ld_valid  & (~alu_valid | ~ptr_q);
    alu_gnt = init_done & alu_valid & (~ld_valid  |  ptr_q);
`ifdef RF_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    // init_done follows the state by one cycle. It rises the cycle after
    // the last sweep write becomes visible.
    done_d  = (state_q == ST_RUN);
    case (state_q)
      ST_INIT: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_REG) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
`else
    done_d  = 1'b1;
`endif
    if (ld_gnt) begin
      ptr_d = 1'b1;
      if (writable(ld_rd)) begin
        we_d    = 1'b1;
        waddr_d = ld_rd;
        wdata_d = ld_data;
      end
    end else if (alu_gnt) begin
      ptr_d = 1'b0;
      if (writable(alu_rd)) begin
        we_d    = 1'b1;
        waddr_d = alu_rd;
        wdata_d = alu_data;
      end
    end
  end

  assign ld_ready  = ld_gnt;
  assign alu_ready = alu_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rf_we     <= we_d;
      rf_waddr  <= waddr_d;
      rf_wdata  <= wdata_d;
      init_done <= done_d;
    end
  end

`ifdef RF_CLEAR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_valid = 1'b0, alu_valid = 1'b0;
  logic [AW-1:0] ld_rd = '0, alu_rd = '0;
  logic [DW-1:0] ld_data = '0, alu_data = '0;
  logic          ld_ready, alu_ready, rf_we, init_done;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write presented on the register-file port must match
  // the oldest expected write. Any write with nothing expected is an error.
  always @(negedge clk) begin
    wr_t e;
    if (reset && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(rf_waddr), 64'(e.a));
        check("wr_data", 64'(rf_wdata), 64'(e.d));
      end
    end
  end

  // One request cycle. The driver checks the hand-computed ready pattern,
  // and for each expected accept to a real register it queues the write.
  task automatic issue(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldd,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] add,
                       input logic el, input logic ea, input string nm);
    @(negedge clk);
    ld_valid = lv;  ld_rd = lrd;  ld_data = ldd;
    alu_valid = av; alu_rd = ard; alu_data = add;
    #1;
    check({nm, " ld_ready"}, 64'(ld_ready), 64'(el));
    check({nm, " alu_ready"}, 64'(alu_ready), 64'(ea));
    if (el && lrd != '0) exp_q.push_back({lrd, ldd});
    if (ea && ard != '0) exp_q.push_back({ard, add});
  endtask

  task automatic idle(input string nm);
    issue(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, nm);
  endtask

  task automatic drain(input string nm);
    repeat (2) @(negedge clk);
    #2;
    check({nm, " drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst rf_we", 64'(rf_we), 64'd0);
    check("rst rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst init_done", 64'(init_done), 64'd0);

`ifdef RF_CLEAR_EN
    // Sweep after reset while the load unit already waits with x5.
    for (int i = 1; i < 32; i++) exp_q.push_back({AW'(i), DW'(0)});
    @(negedge clk);
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h55;
    reset = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      #1;
      check("sweep ld_ready", 64'(ld_ready), 64'd0);
    end
    check("sweep init_done low", 64'(init_done), 64'd0);
    issue(1'b1, 5'd5, 32'h55, 1'b0, '0, '0, 1'b1, 1'b0, "after sweep");
    check("sweep init_done high", 64'(init_done), 64'd1);
    idle("after sweep idle");
    drain("sweep");

    // Reset at sweep address 12, then the sweep restarts from x1.
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    for (int i = 1; i < 32; i++) exp_q.push_back({AW'(i), DW'(0)});
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("midsweep waddr", 64'(rf_waddr), 64'd12);
    #1;
    reset = 1'b0;
    #1;
    check("midsweep rst rf_we", 64'(rf_we), 64'd0);
    check("midsweep rst waddr", 64'(rf_waddr), 64'd0);
    exp_q.delete();
    for (int i = 1; i < 32; i++) exp_q.push_back({AW'(i), DW'(0)});
    @(negedge clk);
    reset = 1'b1;
    repeat (33) @(negedge clk);
    #1;
    check("resweep init_done", 64'(init_done), 64'd1);
    drain("resweep");
`else
    // No sweep: the first edge after release raises init_done, and the
    // request is accepted only after that.
    @(negedge clk);
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h55;
    reset = 1'b1;
    #1;
    check("release ld_ready", 64'(ld_ready), 64'd0);
    check("release init_done", 64'(init_done), 64'd0);
    issue(1'b1, 5'd5, 32'h55, 1'b0, '0, '0, 1'b1, 1'b0, "first");
    check("first init_done", 64'(init_done), 64'd1);
    // This ALU grant returns the pointer to the load port.
    issue(1'b0, '0, '0, 1'b1, 5'd1, 32'h1, 1'b0, 1'b1, "ptr restore");
    idle("first idle");
    drain("first");
`endif

    // From here on, the pointer favours the load port.
    issue(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b1, "alu single");
    idle("alu single idle");
    drain("alu single");

    issue(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b0, "both c1");
    issue(1'b1, 5'd3, 32'h12, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, "both c2");
    issue(1'b1, 5'd3, 32'h12, 1'b1, 5'd4, 32'h23, 1'b1, 1'b0, "both c3");
    issue(1'b0, '0, '0, 1'b1, 5'd4, 32'h23, 1'b0, 1'b1, "both c4");
    idle("both idle");
    drain("both");

    // An x0 write is handshaken but never reaches the register file.
    issue(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b1, 1'b0, "x0");
    idle("x0 idle");
    drain("x0");

    // The pointer now favours the ALU. One ALU grant moves it back.
    issue(1'b0, '0, '0, 1'b1, 5'd10, 32'h77, 1'b0, 1'b1, "ptr fix");
    issue(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 1'b1, 1'b0, "same rd c1");
    issue(1'b0, '0, '0, 1'b1, 5'd9, 32'hB, 1'b0, 1'b1, "same rd c2");
    idle("same rd idle");
    drain("same rd");

    // A single load grant flips the pointer, so the ALU wins the next tie.
    issue(1'b1, 5'd2, 32'h2, 1'b0, '0, '0, 1'b1, 1'b0, "flip single");
    issue(1'b1, 5'd8, 32'h88, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, "flip tie");
    issue(1'b1, 5'd8, 32'h88, 1'b0, '0, '0, 1'b1, 1'b0, "flip tail");
    idle("flip idle");
    drain("flip");

    // Reset in RUN clears the outputs at once.
    issue(1'b1, 5'd11, 32'hCAFE, 1'b0, '0, '0, 1'b1, 1'b0, "midrun");
    idle("midrun idle");
    #2;
    reset = 1'b0;
    #1;
    check("midrun rst rf_we", 64'(rf_we), 64'd0);
    check("midrun rst wdata", 64'(rf_wdata), 64'd0);
    check("midrun rst init_done", 64'(init_done), 64'd0);
    check("midrun queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected end within 200000 time units");
    $fatal(1);
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the single write port of the 32x32 register file between two writeback requesters: port 0 is the load unit and port 1 is the ALU.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- Drives the register file's RegWrite, Write_Reg_Num and WriteData through registered outputs.
- Optionally runs a post-reset clear sweep that zeroes x1..x31 before any writeback is accepted.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register index
- NREG, 32, number of registers (the sweep covers 1..NREG-1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ld_valid  input  1  load unit has a writeback pending
- ld_rd  input  ADDR_W  load destination register
- ld_data  input  DATA_W  load writeback data
- ld_ready  output  1  load writeback accepted this cycle
- alu_valid  input  1  ALU has a writeback pending
- alu_rd  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU writeback data
- alu_ready  output  1  ALU writeback accepted this cycle
- rf_we  output  1  to RegWrite
- rf_waddr  output  ADDR_W  to Write_Reg_Num
- rf_wdata  output  DATA_W  to WriteData
- init_done  output  1  high once the arbiter accepts requests

Behaviour:
- Reset (reset=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, sweep counter=1.
  - Round-robin pointer favours port 0 (load).
  - State becomes INIT if RF_CLEAR_EN is defined, otherwise RUN.
- States: INIT and RUN.
- INIT:
  - ld_ready=alu_ready=0.
  - Each cycle registers rf_we=1, rf_waddr=counter, rf_wdata=0, then increments the counter.
  - After writing NREG-1, moves to RUN and registers init_done=1, so init_done rises the cycle after the last sweep write.
  - Sweep length is NREG-1 cycles (31 by default).
- RUN:
  - init_done=1.
  - ld_ready and alu_ready are combinational from valids, state and pointer. At most one is high per cycle.
  - A handshake completes when valid and ready are both high.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the pointer-favoured port is granted, then the pointer flips to favour the other port.
  - Single grants also flip the pointer away from the granted port.
  - Worst-case wait for a continuously valid requester is 1 cycle.
- Latency: a handshake in cycle N produces rf_we/rf_waddr/rf_wdata in cycle N+1, held for exactly one cycle. rf_we=0 in cycles with no grant.
- x0 writes (rd==0): the handshake completes normally (ready=1), but rf_we stays 0 the next cycle and the data is discarded.
- Same rd from both ports in the same cycle: the winner is written first and the loser in the next grant. The register ends with the loser's value, and requesters must order themselves through the handshake.
- Requesters hold valid, rd and data stable until ready; the arbiter does not sample data on non-ready cycles.
- Reset mid-sweep or mid-RUN: outputs clear immediately, the counter returns to 1 and the sweep restarts from x1. In-flight grants are lost.
- No combinational path from inputs to rf_* outputs.

Optional Feature:
- Macro: RF_CLEAR_EN.
- Defined: after reset the INIT sweep runs as above, and ready signals stay low for NREG-1 cycles.
- Undefined:
  - The INIT state and sweep counter are not built. State is RUN from reset.
  - init_done=0 during reset and registers to 1 on the first clock edge after release.
  - Requests are accepted from that first edge onward.

Test Plan:
- RF_CLEAR_EN defined, release reset, ld_valid=1 held with rd=5:
  - rf_we=1 with waddr 1..31 and wdata=0 on 31 consecutive cycles; ld_ready=0 throughout.
  - init_done=1 afterwards; ld_ready then rises and x5 is written one cycle later.
- RUN, alu_valid=1, rd=7, data=0xDEADBEEF, single cycle: alu_ready=1 that cycle; next cycle rf_we=1, waddr=7, wdata=0xDEADBEEF; the cycle after, rf_we=0.
- RUN, both valid for 4 cycles (ld rd=3/data=0x11, alu rd=4/data=0x22, each new after its accept): grants alternate ld, alu, ld, alu, and rf_waddr sequence is 3, 4, 3, 4.
- RUN, ld_valid=1 with rd=0, data=0xFFFFFFFF: ld_ready=1; next cycle rf_we=0.
- RF_CLEAR_EN, assert reset at sweep address 12, release: rf_we=0 during reset; sweep restarts at waddr=1 and finishes at 31.
- Both valid with rd=9, ld data=0xA, alu data=0xB, pointer favouring ld: rf_wdata=0xA then 0xB on consecutive cycles at waddr 9.
